mux_21_arbiter: RTL

Round-robin arbiter and sequencer for a shared 2:1 multiplexed data channel. Two requesters compete for one registered output port. The block grants one requester at a time, drives the mux select, and moves data beats under a valid/ready handshake. A burst cap guarantees fairness. It sits in front of the 2:1 mux datapath and owns its `sel` line.

---
 rtl/mux_arb_pkg.sv | 38 +++
 rtl/mux_21_bus.sv | 24 ++
 rtl/mux_21_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and defaults for the 2:1 round-robin channel arbiter.
//   arb_state_t   : arbiter FSM states (IDLE, GRANT0, GRANT1)
//   ARB_WIDTH     : default data width
//   ARB_MAX_BURST : default beats per grant tenure (legal 1..15)
//   state_to_gnt  : one-hot grant vector for a state
//   idx_to_state  : grant state for a requester index
package mux_arb_pkg;

    localparam int ARB_WIDTH     = 8;
    localparam int ARB_MAX_BURST = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    function automatic logic [1:0] state_to_gnt(input arb_state_t s);
        logic [1:0] g;
        case (s)
            GRANT0:  g = 2'b01;
            GRANT1:  g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

    function automatic arb_state_t idx_to_state(input logic idx);
        arb_state_t s;
        if (idx) begin
            s = GRANT1;
        end else begin
            s = GRANT0;
        end
        return s;
    endfunction

endpackage

// File: rtl/mux_21_bus.sv
// WIDTH-wide 2:1 data multiplexer feeding the arbiter's output register.
//   sel     : selects mux_in1 when high, mux_in0 when low
//   mux_in0 : requester 0 data
//   mux_in1 : requester 1 data
//   mux_out : selected data
module mux_21_bus #(
    parameter int WIDTH = 8
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] mux_in0,
    input  logic [WIDTH-1:0] mux_in1,
    output logic [WIDTH-1:0] mux_out
);

    // Plain select between the two requester buses.
    always_comb begin
        if (sel) begin
            mux_out = mux_in1;
        end else begin
            mux_out = mux_in0;
        end
    end

endmodule

// File: rtl/mux_21_arbiter.sv
// Round-robin arbiter/sequencer for a shared 2:1 multiplexed channel with a
// burst cap for fairness and a registered valid/ready output stage.
//   clk, rst_n          : clock, synchronous active-low reset
//   req[1:0]            : requester k has a beat on data_ink
//   data_in0, data_in1  : requester data
//   ack[1:0]            : requester k's beat is consumed this cycle (comb.)
//   gnt[1:0]            : registered one-hot grant, 00 when idle
//   sel                 : mux select, index of current/last grant holder
//   out_data, out_valid : registered output beat
//   out_ready           : downstream accepts when out_valid && out_ready
module mux_21_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH     = ARB_WIDTH,
    parameter int MAX_BURST = ARB_MAX_BURST
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] data_in0,
    input  logic [WIDTH-1:0] data_in1,
    output logic [1:0]       ack,
    output logic [1:0]       gnt,
    output logic             sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int               CNT_W    = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t       r_state;
    arb_state_t       w_next_state;
    logic [1:0]       r_gnt;
    logic             r_sel;
    logic             w_next_sel;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             r_last;
    logic             w_next_last;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [WIDTH-1:0] w_mux_out;
    logic             w_slot_free;
    logic [1:0]       w_ack;
    logic             w_accept;
    logic             w_cur_idx;
    logic             w_own_req;
    logic             w_other_req;
    logic             w_cap;
    logic             w_release;

    mux_21_bus #(.WIDTH(WIDTH)) u_bus (
        .sel     (r_sel),
        .mux_in0 (data_in0),
        .mux_in1 (data_in1),
        .mux_out (w_mux_out)
    );

    // Handshake: ack needs the grant, a live request and room in the output
    // register. Masked by rst_n so nothing is consumed in a reset cycle.
    always_comb begin
        w_slot_free = !r_out_valid || out_ready;
        w_ack       = r_gnt & req & {2{w_slot_free}} & {2{rst_n}};
        w_accept    = |w_ack;
        w_cur_idx   = (r_state == GRANT1);
        w_own_req   = w_cur_idx ? req[1] : req[0];
        w_other_req = w_cur_idx ? req[0] : req[1];
        w_cap       = w_accept && (r_cnt == CNT_LAST);
        w_release   = !w_own_req || w_cap;
    end

    // Next state, burst counter and round-robin pointer.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_last  = r_last;
        case (r_state)
            IDLE: begin
                case (req)
                    2'b01:   w_next_state = GRANT0;
                    2'b10:   w_next_state = GRANT1;
                    // Tie goes to whoever did not hold the channel last.
                    2'b11:   w_next_state = r_last ? GRANT0 : GRANT1;
                    default: w_next_state = IDLE;
                endcase
            end
            GRANT0, GRANT1: begin
                if (w_release) begin
                    w_next_last = w_cur_idx;
                    w_next_cnt  = '0;
                    if (w_other_req) begin
                        w_next_state = idx_to_state(!w_cur_idx);
                    end else if (w_cap && w_own_req) begin
                        // Lone requester hit the cap: fresh tenure, no bubble.
                        w_next_state = r_state;
                    end else begin
                        w_next_state = IDLE;
                    end
                end else if (w_accept) begin
                    w_next_cnt = r_cnt + CNT_W'(1);
                end else begin
                    w_next_cnt = r_cnt;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Select follows the next holder and keeps its value through IDLE.
    always_comb begin
        case (w_next_state)
            GRANT0:  w_next_sel = 1'b0;
            GRANT1:  w_next_sel = 1'b1;
            default: w_next_sel = r_sel;
        endcase
    end

    // State, grant, select, counter, pointer and output beat registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_gnt       <= 2'b00;
            r_sel       <= 1'b0;
            r_cnt       <= '0;
            r_last      <= 1'b1;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_gnt   <= state_to_gnt(w_next_state);
            r_sel   <= w_next_sel;
            r_cnt   <= w_next_cnt;
            r_last  <= w_next_last;
            if (w_accept) begin
                r_out_data  <= w_mux_out;
                r_out_valid <= 1'b1;
            end else if (out_ready && r_out_valid) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign ack       = w_ack;
    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule
